// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: operation encoding and controller states.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD     = 4'd0,
        SUB     = 4'd1,
        MUL     = 4'd2,
        DIV     = 4'd3,
        LSL     = 4'd4,
        RSL     = 4'd5,
        ROTL    = 4'd6,
        ROTR    = 4'd7,
        AND     = 4'd8,
        OR      = 4'd9,
        XOR     = 4'd10,
        NAND    = 4'd11,
        NOR     = 4'd12,
        XNOR    = 4'd13,
        GREATER = 4'd14,
        EQUAL   = 4'd15
    } e_alu_mode;

    // DIV already names an operation, so the busy state carries a prefix.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } e_alu_state;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring divider, one quotient bit per cycle; done flags the final iteration
// and quotient/remainder present that iteration's result combinationally.
module alu_div_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q_r, rem_r, d_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] q_nxt, rem_nxt;

    always_comb begin
        shifted = {rem_r, q_r[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, d_r};
        if (!trial[WIDTH+1]) begin
            rem_nxt = trial[WIDTH-1:0];
            q_nxt   = {q_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH-1:0];
            q_nxt   = {q_r[WIDTH-2:0], 1'b0};
        end
    end

    assign busy      = (cnt != '0);
    assign done      = (cnt == CW'(1));
    assign quotient  = q_nxt;
    assign remainder = rem_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            q_r   <= '0;
            rem_r <= '0;
            d_r   <= '0;
        end else if (start) begin
            cnt   <= CW'(WIDTH);
            q_r   <= dividend;
            rem_r <= '0;
            d_r   <= divisor;
        end else if (busy) begin
            cnt   <= cnt - CW'(1);
            q_r   <= q_nxt;
            rem_r <= rem_nxt;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Single-beat ALU with valid/ready handshake; all ops complete in one cycle
// except DIV with a nonzero divisor, which runs through alu_div_iter.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dataA,
    input  logic [WIDTH-1:0] in_dataB,
    input  logic [3:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_aux,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_err
);

    localparam int SHW = $clog2(WIDTH);

    e_alu_state         state;
    e_alu_mode          mode;
    logic [SHW-1:0]     shamt;
    logic               accept, div_start;
    logic               div_busy, div_done;
    logic [WIDTH-1:0]   div_q, div_r;

    logic [WIDTH:0]     sum, diff, lsl_ext, rsl_ext;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_data, res_aux;
    logic               res_cout, res_err;

    assign mode      = e_alu_mode'(in_mode);
    assign shamt     = in_dataB[SHW-1:0];
    assign in_ready  = !reset && (state == ST_IDLE) && !div_busy && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign div_start = accept && (mode == DIV) && (in_dataB != '0);

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (in_dataA),
        .divisor   (in_dataB),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    assign sum     = {1'b0, in_dataA} + {1'b0, in_dataB};
    assign diff    = {1'b0, in_dataA} - {1'b0, in_dataB};
    assign prod    = {{WIDTH{1'b0}}, in_dataA} * {{WIDTH{1'b0}}, in_dataB};
    // Extra bit on each side catches the last bit shifted out.
    assign lsl_ext = {1'b0, in_dataA} << shamt;
    assign rsl_ext = {in_dataA, 1'b0} >> shamt;

    always_comb begin
        res_data = '0;
        res_aux  = '0;
        res_cout = 1'b0;
        res_err  = 1'b0;
        case (mode)
            ADD:     begin res_data = sum[WIDTH-1:0];  res_cout = sum[WIDTH];  end
            SUB:     begin res_data = diff[WIDTH-1:0]; res_cout = diff[WIDTH]; end
            MUL:     {res_aux, res_data} = prod;
            DIV: begin
                if (in_dataB == '0) begin
                    res_data = '1;
                    res_aux  = in_dataA;
                    res_err  = 1'b1;
                end
            end
            LSL:     begin res_data = lsl_ext[WIDTH-1:0]; res_cout = lsl_ext[WIDTH]; end
            RSL:     begin res_data = rsl_ext[WIDTH:1];   res_cout = rsl_ext[0];     end
            ROTL:    res_data = (in_dataA << shamt) | (in_dataA >> (WIDTH - int'(shamt)));
            ROTR:    res_data = (in_dataA >> shamt) | (in_dataA << (WIDTH - int'(shamt)));
            AND:     res_data = in_dataA & in_dataB;
            OR:      res_data = in_dataA | in_dataB;
            XOR:     res_data = in_dataA ^ in_dataB;
            NAND:    res_data = ~(in_dataA & in_dataB);
            NOR:     res_data = ~(in_dataA | in_dataB);
            XNOR:    res_data = ~(in_dataA ^ in_dataB);
            GREATER: res_data = WIDTH'(in_dataA > in_dataB);
            EQUAL:   res_data = WIDTH'(in_dataA == in_dataB);
            default: res_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_aux   <= '0;
            out_cout  <= 1'b0;
            out_zero  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (div_start) state <= ST_DIV;
                ST_DIV:  if (div_done)  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (div_done) begin
                out_valid <= 1'b1;
                out_data  <= div_q;
                out_aux   <= div_r;
                out_cout  <= 1'b0;
                out_zero  <= (div_q == '0);
                out_err   <= 1'b0;
            end else if (accept && !div_start) begin
                out_valid <= 1'b1;
                out_data  <= res_data;
                out_aux   <= res_aux;
                out_cout  <= res_cout;
                out_zero  <= (res_data == '0);
                out_err   <= res_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed bench for alu_pipe (WIDTH=8) against an arithmetic reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_dataA, in_dataB;
    logic [3:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data, out_aux;
    logic         out_cout, out_zero, out_err;

    int n_checks = 0;
    int n_errors = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dataA  (in_dataA),
        .in_dataB  (in_dataB),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_aux   (out_aux),
        .out_cout  (out_cout),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: results from plain integer arithmetic on the operation's definition.
    function automatic void model(input int m, input int a, input int b,
                                  output int d, output int x, output int c, output int e);
        int s;
        int p;
        s = b % W;
        d = 0; x = 0; c = 0; e = 0;
        case (m)
            0:  begin d = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1:  begin d = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2:  begin p = a * b; d = p % 256; x = p / 256; end
            3:  if (b == 0) begin d = 255; x = a; e = 1; end
                else begin d = a / b; x = a % b; end
            4:  begin d = (a * (1 << s)) % 256; c = (s == 0) ? 0 : (a >> (W - s)) & 1; end
            5:  begin d = a >> s; c = (s == 0) ? 0 : (a >> (s - 1)) & 1; end
            6:  d = ((a << s) | (a >> (W - s))) & 255;
            7:  d = ((a >> s) | (a << (W - s))) & 255;
            8:  d = a & b;
            9:  d = a | b;
            10: d = a ^ b;
            11: d = 255 - (a & b);
            12: d = 255 - (a | b);
            13: d = 255 - (a ^ b);
            14: d = (a > b) ? 1 : 0;
            default: d = (a == b) ? 1 : 0;
        endcase
    endfunction

    // One complete transaction: wait for ready, send, measure latency, check result,
    // optionally hold the result for 'stall' extra cycles before draining it.
    task automatic do_op(input int m, input int a, input int b, input int stall);
        int d, x, c, e, lat, explat, rdy_seen, waited;
        model(m, a, b, d, x, c, e);
        explat = (m == 3 && b != 0) ? W + 1 : 1;
        @(negedge clk);
        out_ready = (stall == 0);
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        in_mode  = 4'(m);
        in_dataA = 8'(a);
        in_dataB = 8'(b);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_dataA = 8'($urandom);
        in_dataB = 8'($urandom);
        in_mode  = 4'($urandom);
        lat = 1;
        rdy_seen = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_seen++;
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency m%0d", m), lat, explat);
        if (explat > 1) check("div_in_ready_low", rdy_seen, 0);
        check($sformatf("data m%0d a%0d b%0d", m, a, b), out_data, d);
        check($sformatf("aux m%0d a%0d b%0d", m, a, b), out_aux, x);
        check($sformatf("cout m%0d a%0d b%0d", m, a, b), out_cout, c);
        check($sformatf("zero m%0d", m), out_zero, (d == 0) ? 1 : 0);
        check($sformatf("err m%0d", m), out_err, e);
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_aux, out_data}, x * 256 + d);
                check("hold_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
            #1;
            check("drain_in_ready", in_ready, 1);
            @(negedge clk);
            check("drained_valid", out_valid, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, x, c, e, pd, px, pc, pe, m, a, b, seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_dataA  = '0;
        in_dataB  = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        #1;
        check("in_ready_in_reset", in_ready, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_aux", out_aux, 0);
        check("rst_flags", {out_cout, out_zero, out_err}, 0);

        do_op(int'(ADD), 'hF0, 'h20, 0);
        do_op(int'(DIV), 200, 7, 0);
        do_op(int'(DIV), 'h55, 0, 0);
        do_op(int'(MUL), 'hFF, 'hFF, 3);
        do_op(int'(LSL), 'h81, 1, 0);
        do_op(int'(RSL), 'h01, 1, 0);
        do_op(int'(LSL), 'hA5, 0, 0);
        do_op(int'(SUB), 3, 5, 0);
        do_op(int'(DIV), 5, 255, 0);

        // Reset three cycles into a division: that beat must never complete.
        @(negedge clk);
        out_ready = 1'b1;
        in_mode = 4'(int'(DIV)); in_dataA = 8'd100; in_dataB = 8'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("in_ready_mid_reset", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_data", out_data, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        do_op(int'(ADD), 1, 1, 0);

        // Back-to-back single-cycle beats at full rate.
        @(negedge clk);
        out_ready = 1'b1;
        pd = 0; px = 0; pc = 0; pe = 0;
        for (int i = 0; i < 12; i++) begin
            m = $urandom_range(0, 15);
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            if (m == 3) b = 0;
            check("b2b_in_ready", in_ready, 1);
            if (i > 0) begin
                check("b2b_valid", out_valid, 1);
                check("b2b_data", {out_aux, out_data}, px * 256 + pd);
                check("b2b_flags", {out_cout, out_err}, pc * 2 + pe);
            end
            model(m, a, b, d, x, c, e);
            pd = d; px = x; pc = c; pe = e;
            in_mode = 4'(m); in_dataA = 8'(a); in_dataB = 8'(b); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_last_valid", out_valid, 1);
        check("b2b_last_data", {out_aux, out_data}, px * 256 + pd);

        for (int i = 0; i < 150; i++) begin
            m = $urandom_range(0, 15);
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            do_op(m, a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal values are powers of two from 4 to 32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand beat valid.
REQ-005 in_ready  output  1  block accepts a beat this cycle.
REQ-006 in_dataA, in_dataB  input  WIDTH  operands, unsigned.
REQ-007 in_mode  input  4  operation select, type e_alu_mode.
REQ-008 out_valid  output  1  result beat valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_data  output  WIDTH  primary result.
REQ-011 out_aux  output  WIDTH  product high half for MUL, remainder for DIV, otherwise 0.
REQ-012 out_cout, out_zero, out_err  output  1 each  carry/borrow/shift-out flag, out_data==0 flag, divide-by-zero flag.

Function
REQ-013 A beat is accepted when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-014 States: IDLE and DIV. IDLE goes to DIV on an accepted DIV with in_dataB!=0. DIV returns to IDLE after exactly WIDTH iteration cycles.
REQ-015 Non-DIV ops, and DIV with in_dataB==0, have a latency of 1: result registers load and out_valid=1 on the edge after acceptance.
REQ-016 DIV with nonzero divisor uses restoring iteration, one quotient bit per cycle; out_valid=1 on the edge WIDTH+1 cycles after acceptance.
REQ-017 out_valid and all result outputs hold stable until out_valid && out_ready; out_valid then clears unless a new beat completes on the same edge.
REQ-018 Back-to-back operation: with out_ready=1, single-cycle ops sustain 1 beat per cycle.
REQ-019 ADD: out_data = (A+B) mod 2^WIDTH; out_cout = bit WIDTH of the WIDTH+1-bit sum.
REQ-020 SUB: out_data = (A-B) mod 2^WIDTH; out_cout = 1 iff A<B (borrow).
REQ-021 MUL: the 2*WIDTH-bit product is split as {out_aux, out_data}; out_cout=0.
REQ-022 DIV: out_data = quotient, out_aux = remainder. If B==0: out_data = all ones, out_aux = A, out_err=1.
REQ-023 LSL, RSL, ROTL, ROTR shift or rotate A by B[log2(WIDTH)-1:0]. For LSL/RSL, out_cout = the last bit shifted out (0 if the amount is 0). Rotates set out_cout=0.
REQ-024 AND, OR, XOR, NAND, NOR, XNOR are bitwise on A and B.
REQ-025 GREATER and EQUAL return 1 or 0 in out_data.
REQ-026 Logic, compare and rotate ops set out_cout=0.
REQ-027 out_err=0 for every op except DIV by zero.
REQ-028 out_zero = (out_data==0) for every op, registered with the result.
REQ-029 Operands and mode are captured at acceptance; later changes on the inputs do not affect an in-flight DIV.

Reset
REQ-030 While reset=1 at a rising edge, the next state is: state=IDLE, out_valid=0, out_data=0, out_aux=0, all flags 0, iteration counter 0.
REQ-031 in_ready=0 during any cycle in which reset=1.
REQ-032 Reset asserted mid-DIV aborts the division; no result is produced for that beat.
REQ-033 A result held awaiting out_ready is discarded on reset.

Structure
REQ-034 Package alu_pkg holds typedef e_alu_mode (ADD=0 … EQUAL=15, 4-bit encoding) and the state enum.
REQ-035 The iterative divider is sub-module alu_div_iter (parameter WIDTH; start/busy/done; quotient/remainder).
REQ-036 All single-cycle ops are combinational in alu_pipe, feeding one output register stage.

Verification (WIDTH=8)
REQ-037 ADD A=0xF0, B=0x20 -> 1 cycle later: out_data=0x10, out_cout=1, out_zero=0.
REQ-038 DIV A=200, B=7 -> out_valid exactly 9 cycles after acceptance, out_data=28, out_aux=4, in_ready=0 throughout.
REQ-039 DIV A=0x55, B=0 -> 1 cycle later: out_data=0xFF, out_aux=0x55, out_err=1.
REQ-040 MUL A=0xFF, B=0xFF with out_ready=0 for 3 cycles -> {out_aux,out_data}=0xFE01 held stable, in_ready=0 until the drain cycle.
REQ-041 LSL A=0x81, B=1 -> out_data=0x02, out_cout=1; then RSL A=0x01, B=1 -> out_data=0, out_zero=1, out_cout=1.
REQ-042 Reset asserted 3 cycles into DIV 100/3 -> out_valid never rises for that beat; the next ADD 1+1 returns 2 one cycle after acceptance.
